// File: rtl/control_fsm.sv
// control_fsm: multi-cycle control unit and instruction decoder for the
// 16-bit processor. It latches the fetched instruction into IR, steps
// through FETCH/DECODE/EXEC/MEM/WB, and drives the register-file, memory,
// PC and ALU control signals that the Data block consumes.
module control_fsm (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [15:0] input_instr,
    input  logic        input_mem_ready,
    input  logic        input_zero,
    output logic [2:0]  output_reg_readA_address,
    output logic [2:0]  output_reg_readB_address,
    output logic [2:0]  output_reg_write_address,
    output logic        output_reg_write,
    output logic [15:0] output_imm,
    output logic        output_branch,
    output logic        output_memToReg,
    output logic        output_mem_read,
    output logic        output_mem_write,
    output logic        output_IR_write,
    output logic        output_PC_write,
    output logic        output_pc_src,
    output logic [2:0]  output_alu_op,
    output logic        output_alu_src_imm,
    output logic [2:0]  output_state,
    output logic        output_halted,
    output logic        output_illegal
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [3:0] OP_R    = 4'h0;
    localparam logic [3:0] OP_ADDI = 4'h1;
    localparam logic [3:0] OP_LW   = 4'h2;
    localparam logic [3:0] OP_SW   = 4'h3;
    localparam logic [3:0] OP_BEQ  = 4'h4;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t      state_q, state_d;
    logic [15:0] ir_q, ir_d;

    logic [3:0]  op;
    logic [2:0]  rd, rs1, rs2, funct;
    logic [5:0]  imm6;
    logic        op_legal;

    assign op    = ir_q[15:12];
    assign rd    = ir_q[11:9];
    assign rs1   = ir_q[8:6];
    assign rs2   = ir_q[5:3];
    assign funct = ir_q[2:0];
    assign imm6  = ir_q[5:0];

    // Classify the latched opcode as one the datapath knows how to execute
    always_comb begin
        op_legal = 1'b0;
        case (op)
            OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_HALT: op_legal = 1'b1;
            default:                                      op_legal = 1'b0;
        endcase
    end

    // Next-state and next-IR selection; IR only moves on a completed fetch
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        case (state_q)
            S_FETCH: begin
                if (input_mem_ready) begin
                    ir_d    = input_instr;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (op == OP_HALT) begin
                    state_d = S_HALT;
                end else if (!op_legal) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (op)
                    OP_R, OP_ADDI: state_d = S_WB;
                    OP_LW, OP_SW:  state_d = S_MEM;
                    default:       state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                if (input_mem_ready) begin
                    state_d = (op == OP_LW) ? S_WB : S_FETCH;
                end
            end
            S_WB:    state_d = S_FETCH;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    // State and instruction register; reset drops back to an empty FETCH
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_FETCH;
            ir_q    <= 16'h0000;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    // Output decode from state and IR; strobes are also gated by RST_N so an
    // access in flight is abandoned the instant reset is asserted
    always_comb begin
        output_state             = state_q;
        output_reg_readA_address = rs1;
        output_reg_readB_address = (op == OP_R) ? rs2 : rd;
        output_reg_write_address = rd;
        output_imm               = {{10{imm6[5]}}, imm6};

        output_alu_op      = 3'b000;
        output_alu_src_imm = 1'b0;
        case (op)
            OP_R:                  output_alu_op = funct;
            OP_ADDI, OP_LW, OP_SW: output_alu_src_imm = 1'b1;
            OP_BEQ:                output_alu_op = 3'b001;
            default:               output_alu_op = 3'b000;
        endcase

        output_reg_write = 1'b0;
        output_memToReg  = 1'b0;
        output_mem_read  = 1'b0;
        output_mem_write = 1'b0;
        output_IR_write  = 1'b0;
        output_PC_write  = 1'b0;
        output_pc_src    = 1'b0;
        output_branch    = 1'b0;
        output_halted    = 1'b0;
        output_illegal   = 1'b0;

        if (RST_N) begin
            case (state_q)
                S_FETCH: begin
                    output_mem_read = 1'b1;
                    output_IR_write = input_mem_ready;
                    output_PC_write = input_mem_ready;
                end
                S_DECODE: begin
                    output_illegal = !op_legal;
                end
                S_EXEC: begin
                    if (op == OP_BEQ) begin
                        output_branch   = 1'b1;
                        output_pc_src   = 1'b1;
                        output_PC_write = input_zero;
                    end
                end
                S_MEM: begin
                    output_mem_read  = (op == OP_LW);
                    output_mem_write = (op == OP_SW);
                end
                S_WB: begin
                    output_reg_write = 1'b1;
                    output_memToReg  = (op == OP_LW);
                end
                S_HALT: begin
                    output_halted = 1'b1;
                end
                default: begin
                    output_halted = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/control_fsm.md
# control_fsm

Multi-cycle control unit and instruction decoder for the 16-bit processor. It latches each fetched instruction into an internal IR and sequences FETCH/DECODE/EXEC/MEM/WB. It drives the register-file read/write addresses, write enable, sign-extended immediate, branch and memToReg selects consumed by the Data block, plus the memory, PC and ALU control strobes. It is the producer side of the Data block's control interface.

## Interface
Parameters: none (16-bit datapath, 3-bit register addresses fixed).
- CLK  input  1  system clock, rising edge
- RST_N  input  1  asynchronous, active-low reset
- input_instr  input  16  instruction word from memory, valid when input_mem_ready=1 in FETCH
- input_mem_ready  input  1  memory handshake: access completes this cycle
- input_zero  input  1  ALU zero flag, valid in EXEC
- output_reg_readA_address / output_reg_readB_address / output_reg_write_address  output  3 each  register file addresses
- output_reg_write  output  1  register write enable
- output_imm  output  16  sign-extended IR[5:0]
- output_branch  output  1  branch instruction in EXEC
- output_memToReg  output  1  WB source: 1=MDR, 0=ALUOut
- output_mem_read / output_mem_write  output  1 each  memory access strobes
- output_IR_write  output  1  instruction latched this cycle
- output_PC_write  output  1  PC update this cycle
- output_pc_src  output  1  0=PC+1, 1=branch target
- output_alu_op  output  3  ALU function
- output_alu_src_imm  output  1  ALU B operand: 1=imm, 0=reg B
- output_state  output  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5
- output_halted  output  1  HALT state
- output_illegal  output  1  one-cycle pulse, undefined opcode

## Operation
- IR fields: op=IR[15:12], rd=IR[11:9], rs1=IR[8:6], rs2=IR[5:3], funct=IR[2:0], imm6=IR[5:0].
- Outputs decode from the registered IR and state only.
- readA=rs1 always. readB=rs2 for op 0x0, rd for all other opcodes. write address=rd. output_imm={{10{imm6[5]}},imm6}.
- Opcodes:
  - 0x0 R-type: rd<=rs1 op rs2, alu_op=funct.
  - 0x1 ADDI, 0x2 LW, 0x3 SW: alu_op=000 (add), alu_src_imm=1.
  - 0x4 BEQ: alu_op=001 (sub), alu_src_imm=0.
  - 0xF HALT.
  - All other opcodes are illegal.
- FETCH: mem_read=1. When input_mem_ready=1: IR<=input_instr, IR_write=1, PC_write=1, pc_src=0, go to DECODE. Otherwise hold in FETCH.
- DECODE: one cycle. HALT goes to HALT. Illegal pulses output_illegal and goes to FETCH. All others go to EXEC.
- EXEC:
  - R/ADDI go to WB. LW/SW go to MEM.
  - BEQ: branch=1, PC_write=input_zero, pc_src=1, then go to FETCH.
- MEM: LW asserts mem_read, SW asserts mem_write, both held until input_mem_ready=1. Then LW goes to WB and SW goes to FETCH.
- WB: reg_write=1 for one cycle, memToReg=1 for LW and 0 for R/ADDI, then go to FETCH. Writes to r0 are not suppressed here.
- HALT: all strobes 0, halted=1. Left only via reset.

## Timing
- Reset (RST_N=0, asynchronous): state=FETCH and IR=0000 immediately. As a result:
  - all strobes are 0; reg_write, mem_read/write, IR_write, PC_write, branch, memToReg, pc_src, alu_src_imm, halted and illegal are all 0;
  - addresses=0, imm=0000, alu_op=000.
- After RST_N deasserts, mem_read rises in the first FETCH cycle.
- Combinational input-to-output paths are limited to:
  - PC_write and IR_write from input_mem_ready in FETCH;
  - PC_write from input_zero in BEQ EXEC.
- Cycle counts with zero wait states: R/ADDI 4, LW 5, SW 4, BEQ 3, illegal 2. Each cycle of input_mem_ready=0 in FETCH or MEM adds one cycle.
- Memory strobes stay asserted and stable while waiting. The address-relevant outputs (IR-derived) do not change.
- Reset mid-access abandons the access. Strobes drop asynchronously, and no partial writeback occurs.
- IR changes only on IR_write. Register addresses are therefore stable from DECODE through WB.

## Test plan
- Reset: hold RST_N=0 with random inputs -> state=0, all strobes 0, addresses 0, output_imm=0000. Release -> mem_read=1 in FETCH.
- R-type 0x0A51, mem_ready=1:
  - FETCH: IR_write=1, PC_write=1.
  - EXEC: readA=1, readB=2, alu_op=001, alu_src_imm=0.
  - WB: reg_write=1, write address=5, memToReg=0.
  - Back in FETCH on cycle 5.
- LW 0x273E, mem_ready low for 2 MEM cycles:
  - output_imm=FFFE, alu_src_imm=1.
  - mem_read held for 3 MEM cycles.
  - WB: reg_write=1, write address=3, memToReg=1.
  - Total 7 cycles.
- BEQ 0x4443:
  - input_zero=1 -> EXEC: branch=1, PC_write=1, pc_src=1, output_imm=0003.
  - input_zero=0 -> PC_write=0.
  - Both cases return to FETCH after 3 cycles.
- Illegal 0x7000 -> output_illegal pulses for exactly one cycle in DECODE, no reg_write or mem strobes, then FETCH. HALT 0xF000 -> halted=1 and all strobes 0 for 20+ cycles, cleared only by RST_N=0.
- SW 0x3A41 with mem_ready=0 in MEM, RST_N pulsed low mid-MEM -> mem_write falls without waiting for a clock edge, state=FETCH, reg_write never asserted.
